// File: rtl/snn_spi_config.sv
// snn_spi_config: SPI (mode 0) slave that holds the configuration registers of a
// small spiking neural network. Each 16-bit frame has an address byte and a data
// byte, both MSB first. addr[7]=0 writes a register. addr[7]=1 reads the register
// at addr[6:0] back on spi_miso while the data byte is being clocked.
//
// Ports:
//   clk, rst_n   system clock; synchronous active-low reset
//   spi_clk      SPI clock (mode 0), asynchronous to clk
//   spi_cs_n     SPI chip select, active-low
//   spi_mosi     SPI serial data in
//   spi_miso     SPI serial readback data (0 outside the data byte)
//   threshold    neuron firing threshold        (addr 0x00)
//   leak_rate    membrane leak per step         (addr 0x01)
//   refractory   refractory period in cycles    (addr 0x02)
//   weights      weight[i][j] at bits [(i*NUM_OUT+j)*8 +: 8] (addr 0x10 + i*NUM_OUT + j)
//   cfg_wr       one-cycle pulse on every committed register write
module snn_spi_config #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spi_clk,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic [7:0]                  threshold,
  output logic [7:0]                  leak_rate,
  output logic [7:0]                  refractory,
  output logic [NUM_IN*NUM_OUT*8-1:0] weights,
  output logic                        cfg_wr
);

  localparam int unsigned NW = NUM_IN * NUM_OUT;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic [1:0] sclk_s, cs_s, mosi_s;
  logic       sclk_prev;
  logic       sclk, cs_sync, mosi;
  logic       rise, fall;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rd_q, rd_d;
  logic       commit;
  logic [7:0] new_byte;
  logic [7:0] lookup;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s    <= '0;
      cs_s      <= '1;
      mosi_s    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[0], spi_clk};
      cs_s      <= {cs_s[0], spi_cs_n};
      mosi_s    <= {mosi_s[0], spi_mosi};
      sclk_prev <= sclk_s[1];
    end
  end

  assign sclk    = sclk_s[1];
  assign cs_sync = cs_s[1];
  assign mosi    = mosi_s[1];
  assign rise    = !sclk_prev && sclk;
  assign fall    = sclk_prev && !sclk;

  // Byte as it will look after the current rise has been shifted in.
  assign new_byte = {sh_q[6:0], mosi};

  // Readback value for the address byte completing on this rise.
  always_comb begin
    lookup = '0;
    if (new_byte[6:0] == 7'h00)      lookup = threshold;
    else if (new_byte[6:0] == 7'h01) lookup = leak_rate;
    else if (new_byte[6:0] == 7'h02) lookup = refractory;
    else begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (new_byte[6:0] == 7'(k + 16)) lookup = weights[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
    end
  end

  // cnt_q counts rises received so far in the frame (0..15 while receiving).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    commit  = 1'b0;
    if (cs_sync) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ADDR;
          cnt_d   = '0;
        end
        ADDR: begin
          if (rise) begin
            sh_d  = new_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              addr_d  = new_byte;
              rd_d    = new_byte[7] ? lookup : '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (rise) begin
            sh_d  = new_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              commit  = 1'b1;
              state_d = DONE;
            end
          end else if (fall && cnt_q >= 4'd9) begin
            // The fall after rise 8 keeps bit 7 on the line for the master's rise 9.
            rd_d = {rd_q[6:0], 1'b0};
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign spi_miso = (state_q == DATA) && rd_q[7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      threshold  <= 8'd64;
      leak_rate  <= 8'd1;
      refractory <= 8'd4;
      weights    <= '0;
      cfg_wr     <= 1'b0;
    end else begin
      cfg_wr <= 1'b0;
      if (commit && !addr_q[7]) begin
        if (addr_q[6:0] == 7'h00) begin
          threshold <= new_byte;
          cfg_wr    <= 1'b1;
        end else if (addr_q[6:0] == 7'h01) begin
          leak_rate <= new_byte;
          cfg_wr    <= 1'b1;
        end else if (addr_q[6:0] == 7'h02) begin
          refractory <= new_byte;
          cfg_wr     <= 1'b1;
        end else begin
          for (int unsigned k = 0; k < NW; k++) begin
            if (addr_q[6:0] == 7'(k + 16)) begin
              weights[k*8 +: 8] <= new_byte;
              cfg_wr            <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snn_spi_config.sv
// Bench for snn_spi_config: directed frames, then random ones. The register file is
// modelled as plain variables. Expected writes and readback bytes are queued when a
// frame is issued, and a monitor drains the queues as the DUT presents cfg_wr pulses
// or as the driver delivers captured readback bytes.
module tb_snn_spi_config;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 3;
  localparam int NW      = NUM_IN * NUM_OUT;
  localparam int HALF    = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic [7:0] threshold, leak_rate, refractory;
  logic [NW*8-1:0] weights;
  logic cfg_wr;

  snn_spi_config #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .threshold(threshold),
    .leak_rate(leak_rate), .refractory(refractory), .weights(weights),
    .cfg_wr(cfg_wr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl_thr, mdl_leak, mdl_ref;
  logic [7:0] mdl_w[NW];

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] obs_rd_q[$];
  int         exp_pulses = 0;
  int         pulses = 0;
  logic       cfg_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mdl_valid(input logic [6:0] a);
    return (a < 7'd3) || (a >= 7'd16 && int'(a) < 16 + NW);
  endfunction

  function automatic logic [7:0] mdl_read(input logic [6:0] a);
    if (a == 7'd0) return mdl_thr;
    if (a == 7'd1) return mdl_leak;
    if (a == 7'd2) return mdl_ref;
    if (a >= 7'd16 && int'(a) < 16 + NW) return mdl_w[int'(a) - 16];
    return 8'h00;
  endfunction

  function automatic logic [7:0] dut_reg(input logic [6:0] a);
    int idx;
    if (a == 7'd0) return threshold;
    if (a == 7'd1) return leak_rate;
    if (a == 7'd2) return refractory;
    idx = int'(a) - 16;
    if (idx >= 0 && idx < NW) return weights[idx*8 +: 8];
    return 8'hxx;
  endfunction

  task automatic mdl_reset();
    mdl_thr  = 8'd64;
    mdl_leak = 8'd1;
    mdl_ref  = 8'd4;
    for (int k = 0; k < NW; k++) mdl_w[k] = 8'd0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    obs_rd_q.delete();
  endtask

  // Monitor: consumes expected writes on each cfg_wr pulse and readback bytes as captured.
  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] o, x;
    if (rst_n && cfg_wr) begin
      pulses++;
      chk("cfg_wr_width", {31'd0, cfg_prev}, 32'd0);
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_wr_unexpected: got pulse expected none (threshold=%0d)", threshold);
      end else begin
        e = exp_wr_q.pop_front();
        chk($sformatf("wr_%02h", e.a), {24'd0, dut_reg(e.a)}, {24'd0, e.d});
      end
    end
    cfg_prev = cfg_wr;
    if (obs_rd_q.size() > 0) begin
      o = obs_rd_q.pop_front();
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL readback_unexpected: got %02h expected none", o);
      end else begin
        x = exp_rd_q.pop_front();
        checks--;
        chk("readback", {24'd0, o}, {24'd0, x});
      end
    end
  end

  // Drives one frame of nbits bits; rst_at >= 0 pulses rst_n before that bit.
  task automatic spi_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                           input int rst_at, output logic [7:0] rdb, output logic amiso);
    logic [15:0] w;
    w = {a, d};
    rdb = '0;
    amiso = 1'b0;
    spi_cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #30;
        rst_n = 1'b1;
      end
      spi_mosi = w[15-i];
      #(HALF);
      if (i < 8) amiso = amiso | spi_miso;
      else       rdb = {rdb[6:0], spi_miso};
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
    #(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(2*HALF);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":threshold"}, {24'd0, threshold}, {24'd0, mdl_thr});
    chk({tag, ":leak_rate"}, {24'd0, leak_rate}, {24'd0, mdl_leak});
    chk({tag, ":refractory"}, {24'd0, refractory}, {24'd0, mdl_ref});
    for (int k = 0; k < NW; k++)
      chk($sformatf("%s:weight%0d", tag, k), {24'd0, weights[k*8 +: 8]}, {24'd0, mdl_w[k]});
    chk({tag, ":pending_writes"}, exp_wr_q.size(), 32'd0);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                          input string tag, output logic [7:0] rdb);
    logic amiso;
    if (nbits == 16) begin
      if (a[7]) begin
        exp_rd_q.push_back(mdl_read(a[6:0]));
      end else if (mdl_valid(a[6:0])) begin
        exp_wr_q.push_back('{a: a[6:0], d: d});
        exp_pulses++;
        if (a[6:0] == 7'd0)      mdl_thr = d;
        else if (a[6:0] == 7'd1) mdl_leak = d;
        else if (a[6:0] == 7'd2) mdl_ref = d;
        else                     mdl_w[int'(a[6:0]) - 16] = d;
      end
    end
    spi_frame(a, d, nbits, -1, rdb, amiso);
    if (nbits == 16 && a[7]) obs_rd_q.push_back(rdb);
    chk({tag, ":miso_addr_phase"}, {31'd0, amiso}, 32'd0);
    chk({tag, ":miso_idle"}, {31'd0, spi_miso}, 32'd0);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rdb;
    logic       amiso;
    logic [7:0] a, d;
    int         r, nb;
    mdl_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset:cfg_wr", {31'd0, cfg_wr}, 32'd0);
    chk("reset:miso", {31'd0, spi_miso}, 32'd0);
    check_all("reset");

    do_frame(8'h00, 8'd50, 16, "thr", rdb);
    do_frame(8'h01, 8'd5, 16, "leak", rdb);
    do_frame(8'h02, 8'd10, 16, "ref", rdb);
    chk("param_pulses", pulses, 32'd3);

    do_frame(8'h10, 8'd30, 16, "w10", rdb);
    do_frame(8'h11, 8'd20, 16, "w11", rdb);
    do_frame(8'h12, 8'd10, 16, "w12", rdb);
    do_frame(8'h13, 8'd15, 16, "w13", rdb);
    do_frame(8'h14, 8'd25, 16, "w14", rdb);
    do_frame(8'h15, 8'd35, 16, "w15", rdb);
    do_frame(8'h1B, 8'd7, 16, "w1B", rdb);
    chk("w32_const", {24'd0, weights[11*8 +: 8]}, 32'd7);

    do_frame(8'h05, 8'd99, 16, "inv05", rdb);
    do_frame(8'h1C, 8'd99, 16, "inv1C", rdb);
    do_frame(8'h00, 8'd77, 12, "abort", rdb);
    chk("abort_thr_const", {24'd0, threshold}, 32'd50);

    do_frame(8'h80, 8'h00, 16, "rd80", rdb);
    chk("rd80_const", {24'd0, rdb}, 32'h32);
    do_frame(8'h85, 8'h00, 16, "rd85", rdb);
    chk("rd85_const", {24'd0, rdb}, 32'h00);

    // Reset during the data byte: frame is lost, registers go back to defaults.
    @(negedge clk);
    spi_frame(8'h01, 8'd200, 16, 11, rdb, amiso);
    mdl_reset();
    @(negedge clk);
    chk("rstmid:leak", {24'd0, leak_rate}, 32'd1);
    check_all("rstmid");
    do_frame(8'h01, 8'd9, 16, "post_rst", rdb);
    chk("post_rst_leak_const", {24'd0, leak_rate}, 32'd9);

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      d  = 8'($urandom_range(0, 255));
      nb = 16;
      if (r <= 4) begin
        r = $urandom_range(0, 3);
        a = (r == 3) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(16, 16 + NW - 1));
      end else if (r == 5) begin
        a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(3, 15))
                                        : 8'($urandom_range(16 + NW, 127));
      end else if (r <= 7) begin
        a = 8'h80 | (($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2))
                                                 : 8'($urandom_range(0, 127)));
      end else if (r == 8) begin
        a  = 8'($urandom_range(0, 255));
        nb = $urandom_range(1, 15);
      end else begin
        a = 8'($urandom_range(16, 16 + NW - 1));
      end
      do_frame(a, d, nb, $sformatf("rnd%0d", n), rdb);
    end

    repeat (10) @(negedge clk);
    chk("cfg_wr_count", pulses, exp_pulses);
    chk("reads_drained", exp_rd_q.size() + obs_rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
